// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph codes and 7-segment patterns for the display scanner.
// Patterns are active-low, bit order gfedcba (bit 6 = segment g).
package seg_pkg;

    typedef logic [4:0] glyph_t;
    typedef logic [6:0] seg_t;

    localparam glyph_t GLYPH_BLANK = 5'd16;
    localparam glyph_t GLYPH_DASH  = 5'd17;
    localparam glyph_t GLYPH_R     = 5'd18;
    localparam glyph_t GLYPH_N     = 5'd19;
    localparam glyph_t GLYPH_O     = 5'd20;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_R     = 7'b0101111;
    localparam seg_t SEG_N     = 7'b0101011;
    localparam seg_t SEG_O     = 7'b0100011;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_glyph_dec.sv
// seg_glyph_dec: combinational glyph-code to 7-segment decoder.
// Ports:
//   i_code  in  5  glyph code (0-15 hex, 16 blank, 17 dash, 18 r, 19 n, 20 o)
//   o_seg   out 7  active-low segments gfedcba; unknown codes decode to blank
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            5'd0:       o_seg = SEG_0;
            5'd1:       o_seg = SEG_1;
            5'd2:       o_seg = SEG_2;
            5'd3:       o_seg = SEG_3;
            5'd4:       o_seg = SEG_4;
            5'd5:       o_seg = SEG_5;
            5'd6:       o_seg = SEG_6;
            5'd7:       o_seg = SEG_7;
            5'd8:       o_seg = SEG_8;
            5'd9:       o_seg = SEG_9;
            5'd10:      o_seg = SEG_A;
            5'd11:      o_seg = SEG_B;
            5'd12:      o_seg = SEG_C;
            5'd13:      o_seg = SEG_D;
            5'd14:      o_seg = SEG_E;
            5'd15:      o_seg = SEG_F;
            GLYPH_DASH: o_seg = SEG_DASH;
            GLYPH_R:    o_seg = SEG_R;
            GLYPH_N:    o_seg = SEG_N;
            GLYPH_O:    o_seg = SEG_O;
            default:    o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner.
// Cycles one active-low anode per REFRESH_DIV clocks, decodes the selected
// digit's glyph, and applies blink and leading-zero blanking. Input state is
// captured into shadow registers only at frame wrap so a frame is never torn.
// Ports:
//   fclk        in   1             system clock
//   rst         in   1             asynchronous active-high reset
//   glyphs      in   5*NUM_DIGITS  per-digit glyph codes, digit 0 in [4:0]
//   bclk        in   1             asynchronous blink clock
//   blink_mask  in   NUM_DIGITS    digits blanked while synchronised bclk is low
//   lzb_en      in   1             leading-zero blanking enable
//   anode       out  NUM_DIGITS    active-low digit enables, one-hot-low
//   seg_out     out  7             active-low segments gfedcba
// Optional (macro SEG_SCAN_DP_EN):
//   dp_mask     in   NUM_DIGITS    per-digit decimal point enable
//   dp_out      out  1             active-low decimal point
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    fclk,
    input  logic                    rst,
    input  logic [5*NUM_DIGITS-1:0] glyphs,
    input  logic                    bclk,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lzb_en,
`ifdef SEG_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic                    dp_out,
`endif
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg_out
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_bclk_m;
    logic                    r_bclk_s;
    logic [5*NUM_DIGITS-1:0] r_sh_glyphs;
    logic [NUM_DIGITS-1:0]   r_sh_blink;
    logic                    r_sh_lzb;

    logic                    w_tick;
    logic                    w_wrap;
    logic [4:0]              w_code;
    logic [6:0]              w_dec;
    logic                    w_blink_sel;
    logic                    w_lz_sel;
    logic                    w_blank_blink;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_lz_run;
    logic [NUM_DIGITS-1:0]   w_anode_nxt;

`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    w_dp_sel;
`endif

    assign w_tick = (r_presc == PRE_MAX);
    assign w_wrap = w_tick && (r_idx == IDX_MAX);

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_bclk_m    <= 1'b0;
            r_bclk_s    <= 1'b0;
            r_sh_glyphs <= {NUM_DIGITS{GLYPH_BLANK}};
            r_sh_blink  <= '0;
            r_sh_lzb    <= 1'b0;
        end else begin
            r_bclk_m <= bclk;
            r_bclk_s <= r_bclk_m;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_wrap) begin
                r_sh_glyphs <= glyphs;
                r_sh_blink  <= blink_mask;
                r_sh_lzb    <= lzb_en;
            end
        end
    end

`ifdef SEG_SCAN_DP_EN
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_sh_dp <= '0;
        end else if (w_wrap) begin
            r_sh_dp <= dp_mask;
        end
    end
`endif

    // A digit is leading-zero blanked when it and every digit above it hold
    // code 0; digit 0 is excluded so a zero value still shows one "0".
    always_comb begin
        w_lz_blank = '0;
        w_lz_run   = r_sh_lzb;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run      = w_lz_run & (r_sh_glyphs[5*i +: 5] == 5'd0);
            w_lz_blank[i] = w_lz_run;
        end
    end

    always_comb begin
        w_code      = GLYPH_BLANK;
        w_blink_sel = 1'b0;
        w_lz_sel    = 1'b0;
        w_anode_nxt = '1;
`ifdef SEG_SCAN_DP_EN
        w_dp_sel    = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code         = r_sh_glyphs[5*i +: 5];
                w_blink_sel    = r_sh_blink[i];
                w_lz_sel       = w_lz_blank[i];
                w_anode_nxt[i] = 1'b0;
`ifdef SEG_SCAN_DP_EN
                w_dp_sel       = r_sh_dp[i];
`endif
            end
        end
    end

    assign w_blank_blink = ~r_bclk_s & w_blink_sel;

    seg_glyph_dec u_dec (
        .i_code (w_code),
        .o_seg  (w_dec)
    );

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            anode   <= '1;
            seg_out <= SEG_BLANK;
        end else begin
            anode   <= w_anode_nxt;
            seg_out <= (w_blank_blink | w_lz_sel) ? SEG_BLANK : w_dec;
        end
    end

`ifdef SEG_SCAN_DP_EN
    // The decimal point follows blink blanking but ignores leading-zero
    // blanking, so "0.5" style readouts keep their point.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            dp_out <= 1'b1;
        end else begin
            dp_out <= w_blank_blink ? 1'b1 : ~w_dp_sel;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic        fclk = 1'b0;
    logic        rst;
    logic [19:0] glyphs;
    logic        bclk;
    logic [3:0]  blink_mask;
    logic        lzb_en;
    logic [3:0]  anode;
    logic [6:0]  seg_out;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  dp_mask;
    logic        dp_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] BLK = 7'b1111111;

    logic [6:0] exp_tab [24] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
        7'b1111111, 7'b0111111, 7'b0101111, 7'b0101011,
        7'b0100011, 7'b1111111, 7'b1111111, 7'b1111111
    };

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .fclk       (fclk),
        .rst        (rst),
        .glyphs     (glyphs),
        .bclk       (bclk),
        .blink_mask (blink_mask),
        .lzb_en     (lzb_en),
`ifdef SEG_SCAN_DP_EN
        .dp_mask    (dp_mask),
        .dp_out     (dp_out),
`endif
        .anode      (anode),
        .seg_out    (seg_out)
    );

    always #5 fclk = ~fclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic check_disp(input string tag, input logic [3:0] a_exp, input logic [6:0] s_exp);
        check_eq({tag, "_anode"}, {28'd0, anode}, {28'd0, a_exp});
        check_eq({tag, "_seg"}, {25'd0, seg_out}, {25'd0, s_exp});
    endtask

    function automatic logic [19:0] pack4(input int c0);
        return {5'(c0 + 3), 5'(c0 + 2), 5'(c0 + 1), 5'(c0)};
    endfunction

    initial begin
        rst        = 1'b1;
        glyphs     = pack4(1);
        bclk       = 1'b1;
        blink_mask = 4'b0000;
        lzb_en     = 1'b0;
`ifdef SEG_SCAN_DP_EN
        dp_mask    = 4'b0000;
`endif
        cyc(3);
        check_disp("reset", 4'b1111, BLK);
`ifdef SEG_SCAN_DP_EN
        check_eq("reset_dp", {31'd0, dp_out}, 32'd1);
`endif

        // release: frame 0 shows blank until the first wrap loads the shadows
        rst = 1'b0;
        cyc(1);  check_disp("rel_d0_blank", 4'b1110, BLK);
        cyc(4);  check_disp("rel_d1_blank", 4'b1101, BLK);
        cyc(4);  check_disp("rel_d2_blank", 4'b1011, BLK);
        cyc(4);  check_disp("rel_d3_blank", 4'b0111, BLK);
        cyc(4);  check_disp("f1_d0", 4'b1110, 7'b1111001);
        cyc(4);  check_disp("f1_d1", 4'b1101, 7'b0100100);
        cyc(4);  check_disp("f1_d2", 4'b1011, 7'b0110000);

        // mid-frame glyph change must not tear the frame
        glyphs = pack4(6);
        cyc(1);  check_disp("tear_d2", 4'b1011, 7'b0110000);
        cyc(3);  check_disp("tear_d3", 4'b0111, 7'b0011001);
        cyc(4);  check_disp("new_d0", 4'b1110, 7'b0000010);
        cyc(4);  check_disp("new_d1", 4'b1101, 7'b1111000);

        // leading-zero blanking, all zeros
        lzb_en = 1'b1;
        glyphs = 20'd0;
        cyc(12); check_disp("lz0_d0", 4'b1110, 7'b1000000);
        cyc(4);  check_disp("lz0_d1", 4'b1101, BLK);
        cyc(4);  check_disp("lz0_d2", 4'b1011, BLK);
        cyc(4);  check_disp("lz0_d3", 4'b0111, BLK);

        // digit3..0 = 0,5,0,7: only digit 3 blanked
        glyphs = {5'd0, 5'd5, 5'd0, 5'd7};
        cyc(4);  check_disp("lz1_d0", 4'b1110, 7'b1111000);
        cyc(4);  check_disp("lz1_d1", 4'b1101, 7'b1000000);
        cyc(4);  check_disp("lz1_d2", 4'b1011, 7'b0010010);
        cyc(4);  check_disp("lz1_d3", 4'b0111, BLK);

        // blink: mask 0011, bclk low
        lzb_en     = 1'b0;
        glyphs     = pack4(1);
        blink_mask = 4'b0011;
        bclk       = 1'b0;
        cyc(4);  check_disp("blk_d0", 4'b1110, BLK);
        cyc(4);  check_disp("blk_d1", 4'b1101, BLK);
        cyc(4);  check_disp("blk_d2", 4'b1011, 7'b0110000);
        cyc(4);  check_disp("blk_d3", 4'b0111, 7'b0011001);
        cyc(4);  check_disp("blk2_d0", 4'b1110, BLK);
        bclk = 1'b1;
        cyc(2);  check_disp("bclk_sync2", 4'b1110, BLK);
        cyc(1);  check_disp("bclk_sync3", 4'b1110, 7'b1111001);
        cyc(1);  check_disp("unblk_d1", 4'b1101, 7'b0100100);

        // asynchronous reset while digit 3 is lit
        cyc(8);  check_disp("pre_rst_d3", 4'b0111, 7'b0011001);
        rst = 1'b1;
        #1;
        check_disp("async_rst", 4'b1111, BLK);

        // restart and sweep every glyph code through the decoder
        glyphs     = pack4(0);
        blink_mask = 4'b0000;
`ifdef SEG_SCAN_DP_EN
        dp_mask    = 4'b0100;
`endif
        cyc(2);
        rst = 1'b0;
        cyc(1);  check_disp("rerel_d0_blank", 4'b1110, BLK);
        cyc(15);
        for (int f = 0; f < 6; f++) begin
            for (int d = 0; d < 4; d++) begin
                logic [3:0] a_exp;
                a_exp = ~(4'b0001 << d);
                cyc(1);
                check_disp($sformatf("sweep_code%0d", 4 * f + d), a_exp, exp_tab[4 * f + d]);
`ifdef SEG_SCAN_DP_EN
                check_eq($sformatf("dp_f%0d_d%0d", f, d), {31'd0, dp_out},
                         (d == 2) ? 32'd0 : 32'd1);
`endif
                if (d == 0) glyphs = pack4(4 * (f + 1));
                cyc(3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, fclk cycles per digit slot (legal >=2).
REQ-003 SHALL use one clock and an asynchronous active-high reset: fclk is the clock, rst is the reset.
REQ-004 SHALL have port fclk  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port glyphs  in  5*NUM_DIGITS  per-digit glyph code; digit 0 (rightmost) in bits [4:0].
REQ-007 SHALL have port bclk  in  1  asynchronous beat/blink clock from the metronome.
REQ-008 SHALL have port blink_mask  in  NUM_DIGITS  digits blanked while synchronised bclk is low.
REQ-009 SHALL have port lzb_en  in  1  leading-zero blanking enable.
REQ-010 SHALL have port anode  out  NUM_DIGITS  active-low digit enable, one-hot-low.
REQ-011 SHALL have port seg_out  out  7  active-low segments, bit order gfedcba (bit 6 = g).

Function
REQ-012 SHALL decode glyph codes: 0-15 hex 0-F; 16 blank; 17 dash (0111111); 18 'r' (0101111); 19 'n' (0101011); 20 'o' (0100011); 21-31 blank.
REQ-013 SHALL use patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; blank=1111111.
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1; the cycle at REFRESH_DIV-1 is a tick, after which it returns to 0.
REQ-015 SHALL advance the scan index on each tick, NUM_DIGITS-1 wrapping to 0.
REQ-016 SHALL copy glyphs, blink_mask and lzb_en into shadow registers on the tick that wraps the index to 0, so a frame is never torn.
REQ-017 SHALL register anode and seg_out every cycle from the current index and shadow state, so both change together one cycle after the index changes.
REQ-018 SHALL drive exactly one anode bit low: anode[idx]=0, all others 1.
REQ-019 SHALL double-flop bclk into fclk; the synchronised value is bclk_s.
REQ-020 SHALL output blank for digit i when bclk_s=0 and shadow blink_mask[i]=1; a change in bclk reaches seg_out within 3 fclk cycles.
REQ-021 SHALL blank, when shadow lzb_en=1, every digit above digit 0 whose code and all higher-digit codes are 0; digit 0 is never blanked by this rule.
REQ-022 SHALL give blink blanking priority over the glyph decode, and combine it with leading-zero blanking by OR.

Reset
REQ-023 SHALL, while rst=1: anode all 1s; seg_out=1111111; prescaler 0; index 0; bclk sync flops 0; shadow glyphs 16 (blank); shadow blink_mask 0; shadow lzb_en 0.
REQ-024 SHALL, after rst deasserts, light digit 0 from the cycle after release, showing blank until the first frame-wrap tick loads the shadow registers.
REQ-025 SHALL, on reset mid-frame, abandon the frame immediately, with no partial digit retained.

Configuration
REQ-026 SHALL, with macro SEG_SCAN_DP_EN defined, add port dp_mask (in, NUM_DIGITS) and port dp_out (out, 1, active-low), with dp_mask shadowed at frame wrap like glyphs and dp_out=~dp_mask[idx] registered alongside seg_out; reset value of dp_out is 1.
REQ-027 SHALL, without SEG_SCAN_DP_EN, have neither port and no decimal-point logic.
REQ-028 SHALL, when SEG_SCAN_DP_EN is defined, blank the decimal point together with the segments under blink (REQ-020), but not under leading-zero blanking.

Structure
REQ-029 SHALL place glyph code localparams (GLYPH_BLANK=16, GLYPH_DASH=17, GLYPH_R=18, GLYPH_N=19, GLYPH_O=20) and the 7-bit pattern constants in shared package seg_pkg.
REQ-030 SHALL implement the decode as a combinational sub-module seg_glyph_dec (5-bit code in, 7-bit pattern out).

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-031 SHALL cover: reset release with glyphs={1,2,3,4} -> anode 1110 blank until first wrap, then sequence 1110,1101,1011,0111 every 4 cycles with seg_out 1111001,0100100,0110000,0011001.
REQ-032 SHALL cover: change glyphs mid-frame at index 2 -> seg_out for indices 2,3 keeps old values; new values appear only from the next index 0.
REQ-033 SHALL cover: lzb_en=1, glyphs (digit3..0)={0,0,0,0} -> digits 3..1 blank, digit 0 shows 1000000; with {0,5,0,7}, only digit 3 is blank.
REQ-034 SHALL cover: blink_mask=0011, bclk held 0 -> digits 0,1 blank, digits 2,3 normal; bclk=1 -> all shown within 3 cycles.
REQ-035 SHALL cover: assert rst while at index 3 -> anode 1111 and seg_out 1111111 in the same cycle, with no clock edge required.
REQ-036 SHALL cover, with SEG_SCAN_DP_EN: dp_mask=0100 -> dp_out=0 only while anode=1011.
